eeprom_boot_loader: RTL

Boot-image loader that sits directly downstream of the EEPROM page reader. It issues one page read per request and packs the returned byte stream into 16-bit big-endian words. It writes those words sequentially into program memory and holds the CPU in reset until the whole image has loaded cleanly. It also owns page sequencing, inter-byte timeout and the load status.

---
 rtl/boot_pkg.sv | 21 ++
 rtl/boot_byte_packer.sv | 78 +++++++
 rtl/eeprom_boot_loader.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared state encoding and error codes for the EEPROM boot loader.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_RECV  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } boot_state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;
  localparam logic [1:0] ERR_CHECKSUM = 2'd3;

endpackage

// File: rtl/boot_byte_packer.sv
// Packs a byte stream into 16-bit big-endian words and holds each in a single write register.
// Latency: mem_we rises the cycle after the odd (low) byte strobe; mem_addr advances the cycle after accept.
// Backpressure: one word of buffering; an odd byte arriving while a word is still unaccepted is reported as ovf.
module boot_byte_packer
  import boot_pkg::*;
#(
  parameter int MEM_AW = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              abort,
  input  logic              byte_vld,
  input  logic [7:0]        byte_dat,
  input  logic              byte_skip,
  input  logic              mem_ready,
  output logic              odd_byte,
  output logic [15:0]       word,
  output logic              word_load,
  output logic              ovf,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we
);

  logic       phase_q;
  logic [7:0] hi_q;
  logic       accept;

  assign accept    = mem_we & mem_ready;
  assign odd_byte  = byte_vld & phase_q;
  assign word      = {hi_q, byte_dat};
  // A word completing in the same cycle as the new odd byte frees the register, so no overflow then.
  assign ovf       = odd_byte & ~byte_skip & mem_we & ~mem_ready;
  assign word_load = odd_byte & ~byte_skip & ~ovf;

  // Even/odd byte toggle and high-byte latch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= 1'b0;
      hi_q    <= 8'h00;
    end else if (clr || abort) begin
      phase_q <= 1'b0;
    end else if (byte_vld) begin
      phase_q <= ~phase_q;
      if (!phase_q) begin
        hi_q <= byte_dat;
      end
    end
  end

  // Write register: loading a new word takes priority over retiring the accepted one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_we    <= 1'b0;
      mem_wdata <= 16'h0000;
    end else if (clr || abort) begin
      mem_we <= 1'b0;
    end else if (word_load) begin
      mem_wdata <= word;
      mem_we    <= 1'b1;
    end else if (accept) begin
      mem_we <= 1'b0;
    end
  end

  // Word address: advances on every accepted write and wraps silently.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr <= '0;
    end else if (clr) begin
      mem_addr <= '0;
    end else if (accept) begin
      mem_addr <= mem_addr + 1'b1;
    end
  end

endmodule

// File: rtl/eeprom_boot_loader.sv
// Loads NPAGES EEPROM pages into program memory as 16-bit words and releases CPU reset on success; BOOT_CHECKSUM_EN makes the last word a checksum.
// Latency: ee_start one cycle after REQ sees ee_busy=0; mem_we one cycle after the odd byte; done one cycle after the last NEXT.
// Backpressure: holds mem_we until mem_ready; a second word arriving before acceptance is an overflow error.
module eeprom_boot_loader #(
  parameter int         PAGE_BYTES = 32,
  parameter int         NPAGES     = 16,
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         MEM_AW     = 12,
  parameter int         TIMEOUT    = 65535
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              go,
  output logic [6:0]        ee_slave_addr,
  output logic [15:0]       ee_page_addr,
  output logic [7:0]        ee_nbytes,
  output logic              ee_start,
  input  logic [7:0]        ee_data,
  input  logic              ee_byte_ready,
  input  logic              ee_busy,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              cpu_reset_n,
  output logic              load_done,
  output logic              load_error,
  output logic [1:0]        err_code
);
  import boot_pkg::*;

  localparam int TW = $clog2(TIMEOUT + 1);

  boot_state_t state_q, state_d;

  logic [15:0]   page_q;
  logic [7:0]    byte_cnt_q;
  logic [TW-1:0] tmo_q;
  logic          start_q, start_d;
  logic          done_q, error_q;
  logic [1:0]    code_q;

  logic          load_clr, recv_enter, page_inc, done_set, err_set, abort;
  logic [1:0]    err_val;

  logic          byte_vld, last_byte, tmo_hit, byte_skip, ck_bad;
  logic          odd_byte, word_load, ovf;
  logic [15:0]   word;

  assign byte_vld  = ee_byte_ready & (state_q == ST_RECV);
  assign last_byte = (byte_cnt_q == 8'(PAGE_BYTES - 1));
  assign tmo_hit   = (tmo_q == TW'(TIMEOUT - 1));

`ifdef BOOT_CHECKSUM_EN
  logic        last_word;
  logic [15:0] sum_q;

  assign last_word = last_byte & (page_q == 16'(NPAGES - 1));
  assign byte_skip = last_word;
  assign ck_bad    = odd_byte & last_word & (word != sum_q);

  // Running modulo-2^16 sum of every word handed to the write register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= 16'h0000;
    end else if (load_clr) begin
      sum_q <= 16'h0000;
    end else if (word_load) begin
      sum_q <= sum_q + word;
    end
  end
`else
  logic unused_pack;

  assign byte_skip   = 1'b0;
  assign ck_bad      = 1'b0;
  assign unused_pack = ^{word, word_load, odd_byte};
`endif

  boot_byte_packer #(
    .MEM_AW (MEM_AW)
  ) u_packer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (load_clr),
    .abort     (abort),
    .byte_vld  (byte_vld),
    .byte_dat  (ee_data),
    .byte_skip (byte_skip),
    .mem_ready (mem_ready),
    .odd_byte  (odd_byte),
    .word      (word),
    .word_load (word_load),
    .ovf       (ovf),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    load_clr   = 1'b0;
    recv_enter = 1'b0;
    page_inc   = 1'b0;
    done_set   = 1'b0;
    err_set    = 1'b0;
    err_val    = ERR_NONE;
    abort      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (go) begin
          load_clr = 1'b1;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!start_q) begin
          if (!ee_busy) begin
            start_d = 1'b1;
          end
        end else if (ee_busy) begin
          start_d    = 1'b0;
          recv_enter = 1'b1;
          state_d    = ST_RECV;
        end
      end
      ST_RECV: begin
        if (byte_vld) begin
          if (ovf) begin
            err_set = 1'b1;
            err_val = ERR_OVERFLOW;
          end else if (ck_bad) begin
            err_set = 1'b1;
            err_val = ERR_CHECKSUM;
          end else if (last_byte) begin
            state_d = ST_DRAIN;
          end
        end else if (tmo_hit) begin
          err_set = 1'b1;
          err_val = ERR_TIMEOUT;
        end
      end
      ST_DRAIN: begin
        if (!ee_busy && !mem_we) begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        page_inc = 1'b1;
        if (page_q == 16'(NPAGES - 1)) begin
          done_set = 1'b1;
          state_d  = ST_DONE;
        end else begin
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Errors abandon the page reader and any pending word immediately.
    if (err_set) begin
      state_d = ST_ERROR;
      start_d = 1'b0;
      abort   = 1'b1;
    end
  end

  // Read-request handshake register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_q <= 1'b0;
    end else begin
      start_q <= start_d;
    end
  end

  // Page index, byte-in-page count and inter-byte timeout counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      page_q     <= 16'h0000;
      byte_cnt_q <= 8'h00;
      tmo_q      <= '0;
    end else begin
      if (load_clr) begin
        page_q <= 16'h0000;
      end else if (page_inc) begin
        page_q <= page_q + 16'd1;
      end
      if (load_clr || recv_enter) begin
        byte_cnt_q <= 8'h00;
      end else if (byte_vld) begin
        byte_cnt_q <= byte_cnt_q + 8'd1;
      end
      if (recv_enter || byte_vld) begin
        tmo_q <= '0;
      end else if (state_q == ST_RECV) begin
        tmo_q <= tmo_q + 1'b1;
      end
    end
  end

  // Sticky load status, cleared only when a new load starts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      code_q  <= ERR_NONE;
    end else if (load_clr) begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      code_q  <= ERR_NONE;
    end else if (err_set) begin
      error_q <= 1'b1;
      code_q  <= err_val;
    end else if (done_set) begin
      done_q <= 1'b1;
    end
  end

  assign ee_slave_addr = SLAVE_ADDR;
  assign ee_nbytes     = 8'(PAGE_BYTES);
  assign ee_page_addr  = page_q;
  assign ee_start      = start_q;
  assign load_done     = done_q;
  assign cpu_reset_n   = done_q;
  assign load_error    = error_q;
  assign err_code      = code_q;

endmodule
